// File: rtl/limit_modeselect.sv
// limit_modeselect: prioritised mode decode plus a bank of digit-coded limit slots with at-limit detect
module limit_modeselect #(
   parameter int DIGITS    = 6,
   parameter int DIGIT_W   = 4,
   parameter int DIGIT_MAX = 9,
   parameter int NUM_SLOTS = 4,
   parameter int SEL_W     = $clog2(NUM_SLOTS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DIGITS*DIGIT_W-1:0] cnt_in,
   input  logic                      carry_set,
   input  logic                      max_set,
   input  logic                      min_set,
   input  logic                      refresh_limits,
   input  logic [SEL_W-1:0]          slot_sel,
   output logic [DIGITS*DIGIT_W-1:0] limit_out,
   output logic                      carry_en,
   output logic                      max_en,
   output logic                      min_en,
   output logic                      at_limit,
   output logic                      refresh_err
);
   localparam int W = DIGITS * DIGIT_W;
   localparam logic [W-1:0] MAX_VAL = {DIGITS{DIGIT_W'(DIGIT_MAX)}};
   typedef enum logic [1:0] {FREE, CARRY, MAX, MIN} mode_t;
   logic [W-1:0] slots [NUM_SLOTS];
   logic [DIGITS-1:0] dig_ok;
   logic hist, wr_edge, wr;
   mode_t n_mode;
   logic [W-1:0] n_lim;
   for (genvar d = 0; d < DIGITS; d++) begin : g_dig
      assign dig_ok[d] = cnt_in[d*DIGIT_W +: DIGIT_W] <= DIGIT_W'(DIGIT_MAX);
   end
   always_comb begin
      wr_edge = refresh_limits & ~hist;
      wr = wr_edge & (&dig_ok);
      n_mode = carry_set ? CARRY : max_set ? MAX : min_set ? MIN : FREE;
      n_lim = wr ? cnt_in : slots[slot_sel];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= MAX_VAL;
         limit_out   <= MAX_VAL;
         hist        <= 1'b1;
         carry_en    <= 1'b0;
         max_en      <= 1'b0;
         min_en      <= 1'b0;
         at_limit    <= 1'b0;
         refresh_err <= 1'b0;
      end else begin
         if (wr) slots[slot_sel] <= cnt_in;
         limit_out   <= n_lim;
         hist        <= refresh_limits;
         carry_en    <= n_mode == CARRY;
         max_en      <= n_mode == MAX;
         min_en      <= n_mode == MIN;
         at_limit    <= (n_mode == MAX || n_mode == MIN) && cnt_in == n_lim;
         refresh_err <= wr_edge & ~(&dig_ok);
      end
   end
endmodule

// File: tb/tb_limit_modeselect.sv
// tb_limit_modeselect: directed vectors with hand-computed expectations for limit_modeselect
module tb_limit_modeselect;
   logic clk = 1'b0;
   logic reset;
   logic [23:0] cnt_in;
   logic carry_set, max_set, min_set, refresh_limits;
   logic [1:0] slot_sel;
   logic [23:0] limit_out;
   logic carry_en, max_en, min_en, at_limit, refresh_err;
   int n_vec = 0;
   int n_err = 0;
   always #5 clk = ~clk;
   limit_modeselect dut (
      .clk(clk), .reset(reset), .cnt_in(cnt_in), .carry_set(carry_set),
      .max_set(max_set), .min_set(min_set), .refresh_limits(refresh_limits),
      .slot_sel(slot_sel), .limit_out(limit_out), .carry_en(carry_en),
      .max_en(max_en), .min_en(min_en), .at_limit(at_limit), .refresh_err(refresh_err)
   );
   task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk_en(input string tag, input logic c, input logic x, input logic m);
      chk({tag, ".carry_en"}, 24'(carry_en), 24'(c));
      chk({tag, ".max_en"}, 24'(max_en), 24'(x));
      chk({tag, ".min_en"}, 24'(min_en), 24'(m));
   endtask
   initial begin
      reset = 1'b1; cnt_in = 24'h0; carry_set = 0; max_set = 0; min_set = 0;
      refresh_limits = 0; slot_sel = 2'd0;
      step(10);
      chk_en("rst", 0, 0, 0);
      chk("rst.at_limit", 24'(at_limit), 24'h0);
      chk("rst.refresh_err", 24'(refresh_err), 24'h0);
      for (int s = 0; s < 4; s++) begin
         slot_sel = 2'(s);
         step();
         chk($sformatf("rst.limit_out[%0d]", s), limit_out, 24'h999999);
      end
      reset = 1'b0; slot_sel = 2'd0;
      step();
      carry_set = 1; max_set = 1;
      step();
      chk_en("carry_over_max", 1, 0, 0);
      step();
      chk_en("carry_hold", 1, 0, 0);
      carry_set = 0;
      step();
      chk_en("max_after_drop", 0, 1, 0);
      min_set = 1;
      step();
      chk_en("min_under_max", 0, 1, 0);
      max_set = 0; min_set = 0;
      step();
      chk_en("free", 0, 0, 0);
      cnt_in = 24'h123456; slot_sel = 2'd0; refresh_limits = 1;
      step();
      chk("wr.limit_out", limit_out, 24'h123456);
      cnt_in = 24'h111111;
      step(4);
      chk("wr.one_write", limit_out, 24'h123456);
      chk("wr.no_err", 24'(refresh_err), 24'h0);
      refresh_limits = 0; slot_sel = 2'd1;
      step();
      chk("sel1.limit_out", limit_out, 24'h999999);
      slot_sel = 2'd0; cnt_in = 24'h12A456; refresh_limits = 1;
      step();
      chk("bad.refresh_err", 24'(refresh_err), 24'h1);
      chk("bad.limit_out", limit_out, 24'h123456);
      refresh_limits = 0;
      step();
      chk("bad.err_1cycle", 24'(refresh_err), 24'h0);
      chk("bad.slot_kept", limit_out, 24'h123456);
      slot_sel = 2'd3; cnt_in = 24'h99999A; refresh_limits = 1;
      step();
      chk("bad_lsd.refresh_err", 24'(refresh_err), 24'h1);
      chk("bad_lsd.limit_out", limit_out, 24'h999999);
      refresh_limits = 0; cnt_in = 24'h909090;
      step();
      refresh_limits = 1;
      step();
      chk("edge9.limit_out", limit_out, 24'h909090);
      chk("edge9.no_err", 24'(refresh_err), 24'h0);
      refresh_limits = 0; slot_sel = 2'd0; max_set = 1; cnt_in = 24'h123455;
      step();
      chk_en("max_mode", 0, 1, 0);
      chk("max.below", 24'(at_limit), 24'h0);
      cnt_in = 24'h123456;
      step();
      chk("max.at_limit", 24'(at_limit), 24'h1);
      carry_set = 1;
      step();
      chk("carry.at_limit", 24'(at_limit), 24'h0);
      chk_en("carry_mode", 1, 0, 0);
      carry_set = 0; max_set = 0; min_set = 1;
      step();
      chk("min.at_limit", 24'(at_limit), 24'h1);
      min_set = 0;
      step();
      chk("free.at_limit", 24'(at_limit), 24'h0);
      max_set = 1; slot_sel = 2'd2; cnt_in = 24'h333333; refresh_limits = 1;
      step();
      chk_en("simul", 0, 1, 0);
      chk("simul.limit_out", limit_out, 24'h333333);
      chk("simul.at_limit", 24'(at_limit), 24'h1);
      max_set = 0; refresh_limits = 0; slot_sel = 2'd0;
      step();
      chk("slot0.kept", limit_out, 24'h123456);
      refresh_limits = 1; cnt_in = 24'h020450; reset = 1;
      step(2);
      chk("rst2.limit_out", limit_out, 24'h999999);
      chk("rst2.at_limit", 24'(at_limit), 24'h0);
      reset = 0;
      step(2);
      chk("rst2.no_write", limit_out, 24'h999999);
      slot_sel = 2'd2;
      step();
      chk("rst2.slot2", limit_out, 24'h999999);
      slot_sel = 2'd0; refresh_limits = 0;
      step();
      refresh_limits = 1;
      step();
      chk("rst2.rewrite", limit_out, 24'h020450);
      refresh_limits = 0;
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
